// File: rtl/servo_slew_limiter.sv
// -----------------------------------------------------------------------------
// servo_slew_limiter
//   Ramps the commanded pan/tilt servo pulse widths toward the latched
//   targets at a bounded rate. Each update instant (step_tick) moves each axis
//   by at most MAX_STEP, landing exactly on target. Reports when the turret
//   is moving and, after SETTLE_TICKS quiet updates, when it has settled.
//
// Optional feature macro: SLEW_ACCEL_EN
//   Defined   : per-axis step size ramps 1,2,..,MAX_STEP; it drops back to 1
//               on reaching target or when the direction of travel reverses.
//   Undefined : fixed step of MAX_STEP.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   target_pan   in   requested pan pulse width (11b)
//   target_tilt  in   requested tilt pulse width (11b)
//   target_valid in   single-cycle load strobe for both targets
//   hold         in   freeze commanded positions while high
//   pan_angle    out  commanded pan pulse width (11b)
//   tilt_angle   out  commanded tilt pulse width (11b)
//   moving       out  either axis differs from its latched target
//   settled      out  SETTLE_TICKS consecutive at-target updates seen
//   step_tick    out  one-cycle pulse on each update instant
//
// States
//   SLEW     | at least one axis away from its target
//   SETTLING | on target, counting quiet step_ticks
//   SETTLED  | on target long enough; settled = 1
// -----------------------------------------------------------------------------
module servo_slew_limiter #(
  parameter int CLOCK_FREQUENCY_MHZ = 50,
  parameter int STEP_PERIOD_US      = 1000,
  parameter int MAX_STEP            = 4,
  parameter int PW_MIN              = 600,
  parameter int PW_MAX              = 2000,
  parameter int PW_HOME             = 1300,
  parameter int SETTLE_TICKS        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] target_pan,
  input  logic [10:0] target_tilt,
  input  logic        target_valid,
  input  logic        hold,
  output logic [10:0] pan_angle,
  output logic [10:0] tilt_angle,
  output logic        moving,
  output logic        settled,
  output logic        step_tick
);

  localparam int TICK_DIV = CLOCK_FREQUENCY_MHZ * STEP_PERIOD_US;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SET_W    = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_TICKS);
  localparam logic [10:0]      PW_MIN_C   = 11'(PW_MIN);
  localparam logic [10:0]      PW_MAX_C   = 11'(PW_MAX);
  localparam logic [10:0]      PW_HOME_C  = 11'(PW_HOME);
  localparam logic [11:0]      STEP_MAX_C = 12'(MAX_STEP);

  typedef enum logic [1:0] {
    SLEW     = 2'd0,
    SETTLING = 2'd1,
    SETTLED  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;

  // Axis 0 = pan, axis 1 = tilt.
  logic [10:0] pos_q [2];
  logic [10:0] pos_d [2];
  logic [10:0] tgt_q [2];
  logic [10:0] tgt_d [2];
  logic [10:0] tgt_in [2];

`ifdef SLEW_ACCEL_EN
  logic [11:0] step_q [2];
  logic [11:0] step_d [2];
  logic        dir_q  [2];   // 1 = last move was downward
  logic        dir_d  [2];
`endif

  function automatic logic [10:0] clamp_pw(input logic [10:0] v);
    if (v < PW_MIN_C)      return PW_MIN_C;
    else if (v > PW_MAX_C) return PW_MAX_C;
    else                   return v;
  endfunction

  // Move cur toward tgt by at most step; lands exactly when within reach.
  function automatic logic [10:0] step_axis(input logic [10:0] cur,
                                            input logic [10:0] tgt,
                                            input logic [11:0] step);
    logic signed [11:0] diff;
    logic        [11:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[11] ? 12'(-diff) : 12'(diff);
    if (mag <= step)   return tgt;
    else if (diff[11]) return cur - step[10:0];
    else               return cur + step[10:0];
  endfunction

  assign tgt_in[0] = target_pan;
  assign tgt_in[1] = target_tilt;

  assign step_tick  = (tick_cnt_q == TICK_LAST);
  assign moving     = (pos_q[0] != tgt_q[0]) || (pos_q[1] != tgt_q[1]);
  assign settled    = (state_q == SETTLED);
  assign pan_angle  = pos_q[0];
  assign tilt_angle = pos_q[1];

  always_comb begin
    tick_cnt_d = step_tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Targets and positions. Stepping uses tgt_q, so a load coinciding with
  // step_tick only takes effect on the following update.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tgt_d[i] = tgt_q[i];
      pos_d[i] = pos_q[i];
`ifdef SLEW_ACCEL_EN
      step_d[i] = step_q[i];
      dir_d[i]  = dir_q[i];
`endif
      if (target_valid) begin
        tgt_d[i] = clamp_pw(tgt_in[i]);
      end
      if (step_tick && !hold) begin
`ifdef SLEW_ACCEL_EN
        begin
          logic        down;
          logic [11:0] eff;
          down = (tgt_q[i] < pos_q[i]);
          eff  = (down != dir_q[i]) ? 12'd1 : step_q[i];
          pos_d[i] = step_axis(pos_q[i], tgt_q[i], eff);
          if (pos_d[i] == tgt_q[i]) begin
            step_d[i] = 12'd1;
          end else begin
            step_d[i] = (eff < STEP_MAX_C) ? eff + 12'd1 : STEP_MAX_C;
            dir_d[i]  = down;
          end
        end
`else
        pos_d[i] = step_axis(pos_q[i], tgt_q[i], STEP_MAX_C);
`endif
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      SLEW: begin
        if (!moving) begin
          state_d      = SETTLING;
          settle_cnt_d = '0;
        end
      end
      SETTLING: begin
        if (moving) begin
          state_d = SLEW;
        end else if (step_tick) begin
          if (settle_cnt_q < SETTLE_MAX) settle_cnt_d = settle_cnt_q + 1'b1;
          if (settle_cnt_d >= SETTLE_MAX) state_d = SETTLED;
        end
      end
      SETTLED: begin
        if (moving) state_d = SLEW;
      end
      default: state_d = SETTLING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SETTLING;
      tick_cnt_q   <= '0;
      settle_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        pos_q[i] <= PW_HOME_C;
        tgt_q[i] <= PW_HOME_C;
`ifdef SLEW_ACCEL_EN
        step_q[i] <= 12'd1;
        dir_q[i]  <= 1'b0;
`endif
      end
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      for (int i = 0; i < 2; i++) begin
        pos_q[i] <= pos_d[i];
        tgt_q[i] <= tgt_d[i];
`ifdef SLEW_ACCEL_EN
        step_q[i] <= step_d[i];
        dir_q[i]  <= dir_d[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_servo_slew_limiter.sv
module tb_servo_slew_limiter;

  logic        clk;
  logic        rst_n;
  logic [10:0] target_pan;
  logic [10:0] target_tilt;
  logic        target_valid;
  logic        hold;
  logic [10:0] pan_angle;
  logic [10:0] tilt_angle;
  logic        moving;
  logic        settled;
  logic        step_tick;

  int vectors;
  int miscompares;

  servo_slew_limiter #(
    .CLOCK_FREQUENCY_MHZ(1),
    .STEP_PERIOD_US     (10),
    .MAX_STEP           (4),
    .PW_MIN             (600),
    .PW_MAX             (2000),
    .PW_HOME            (1300),
    .SETTLE_TICKS       (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .target_pan  (target_pan),
    .target_tilt (target_tilt),
    .target_valid(target_valid),
    .hold        (hold),
    .pan_angle   (pan_angle),
    .tilt_angle  (tilt_angle),
    .moving      (moving),
    .settled     (settled),
    .step_tick   (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the negedge where step_tick is high (before the update edge).
  task automatic wait_tick_pre();
    int n;
    n = 0;
    @(negedge clk);
    while (!step_tick && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!step_tick) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: step_tick=%0b, required 1 within 30 cycles", step_tick);
    end
  endtask

  // Returns at the negedge just after the update edge.
  task automatic wait_tick();
    wait_tick_pre();
    @(negedge clk);
  endtask

  task automatic load(input logic [10:0] p, input logic [10:0] t);
    target_pan   = p;
    target_tilt  = t;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (pan_angle !== 11'd1300 || tilt_angle !== 11'd1300) begin
      miscompares++;
      $display("FAIL reset_pos: pan=%0d tilt=%0d, required 1300/1300", pan_angle, tilt_angle);
    end
    vectors++;
    if (moving !== 1'b0 || settled !== 1'b0 || step_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: moving=%0b settled=%0b tick=%0b, required 0/0/0",
               moving, settled, step_tick);
    end
    for (int k = 1; k <= 4; k++) begin
      wait_tick();
      vectors++;
      if (settled !== (k >= 3)) begin
        miscompares++;
        $display("FAIL reset_settle tick%0d: settled=%0b, required %0b", k, settled, (k >= 3));
      end
    end
  endtask

  task automatic test_small_slew();
    logic [10:0] exp_p;
    load(11'd1320, 11'd1300);
    vectors++;
    if (moving !== 1'b1) begin
      miscompares++;
      $display("FAIL slew_moving_start: moving=%0b, required 1", moving);
    end
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      exp_p = 11'(1300 + 4 * k);
      vectors++;
      if (pan_angle !== exp_p || tilt_angle !== 11'd1300) begin
        miscompares++;
        $display("FAIL slew_step%0d: pan=%0d tilt=%0d, required %0d/1300", k, pan_angle, tilt_angle, exp_p);
      end
      vectors++;
      if (moving !== (k < 5) || settled !== 1'b0) begin
        miscompares++;
        $display("FAIL slew_flags%0d: moving=%0b settled=%0b, required %0b/0", k, moving, settled, (k < 5));
      end
    end
    for (int k = 1; k <= 3; k++) begin
      wait_tick();
      vectors++;
      if (settled !== (k == 3)) begin
        miscompares++;
        $display("FAIL slew_settle%0d: settled=%0b, required %0b", k, settled, (k == 3));
      end
    end
  endtask

  task automatic test_clamp();
    int n;
    load(11'd2047, 11'd100);
    wait_tick();
    vectors++;
`ifdef SLEW_ACCEL_EN
    if (pan_angle !== 11'd1321 || tilt_angle !== 11'd1299) begin
      miscompares++;
      $display("FAIL clamp_first: pan=%0d tilt=%0d, required 1321/1299", pan_angle, tilt_angle);
    end
`else
    if (pan_angle !== 11'd1324 || tilt_angle !== 11'd1296) begin
      miscompares++;
      $display("FAIL clamp_first: pan=%0d tilt=%0d, required 1324/1296", pan_angle, tilt_angle);
    end
`endif
    n = 0;
    while (moving && n < 250) begin
      wait_tick();
      n++;
      vectors++;
      if (pan_angle > 11'd2000 || pan_angle < 11'd600 ||
          tilt_angle > 11'd2000 || tilt_angle < 11'd600) begin
        miscompares++;
        $display("FAIL clamp_bounds: pan=%0d tilt=%0d, required within 600..2000", pan_angle, tilt_angle);
      end
    end
    vectors++;
    if (pan_angle !== 11'd2000 || tilt_angle !== 11'd600 || moving !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_final: pan=%0d tilt=%0d moving=%0b, required 2000/600/0",
               pan_angle, tilt_angle, moving);
    end
  endtask

  task automatic test_exact_landing();
    pulse_reset();
    repeat (3) wait_tick();
    vectors++;
    if (settled !== 1'b1) begin
      miscompares++;
      $display("FAIL land_presettled: settled=%0b, required 1", settled);
    end
`ifdef SLEW_ACCEL_EN
    load(11'd1310, 11'd1300);
    @(negedge clk);
    vectors++;
    if (settled !== 1'b0) begin
      miscompares++;
      $display("FAIL land_drop: settled=%0b, required 0", settled);
    end
    for (int k = 0; k < 4; k++) begin
      logic [10:0] exp_tab [4];
      exp_tab = '{11'd1301, 11'd1303, 11'd1306, 11'd1310};
      wait_tick();
      vectors++;
      if (pan_angle !== exp_tab[k]) begin
        miscompares++;
        $display("FAIL land_accel%0d: pan=%0d, required %0d", k, pan_angle, exp_tab[k]);
      end
    end
`else
    load(11'd1302, 11'd1300);
    @(negedge clk);
    vectors++;
    if (settled !== 1'b0) begin
      miscompares++;
      $display("FAIL land_drop: settled=%0b, required 0", settled);
    end
    wait_tick();
    vectors++;
    if (pan_angle !== 11'd1302 || moving !== 1'b0) begin
      miscompares++;
      $display("FAIL land_exact: pan=%0d moving=%0b, required 1302/0", pan_angle, moving);
    end
`endif
    repeat (3) wait_tick();
    vectors++;
    if (settled !== 1'b1) begin
      miscompares++;
      $display("FAIL land_resettled: settled=%0b, required 1", settled);
    end
    // Re-load of an identical target must leave SETTLED undisturbed.
`ifdef SLEW_ACCEL_EN
    load(11'd1310, 11'd1300);
`else
    load(11'd1302, 11'd1300);
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (settled !== 1'b1 || moving !== 1'b0) begin
      miscompares++;
      $display("FAIL land_reload: settled=%0b moving=%0b, required 1/0", settled, moving);
    end
  endtask

  task automatic test_hold();
    logic [10:0] e1, e2, e3;
`ifdef SLEW_ACCEL_EN
    e1 = 11'd1301; e2 = 11'd1303; e3 = 11'd1306;
`else
    e1 = 11'd1304; e2 = 11'd1308; e3 = 11'd1312;
`endif
    pulse_reset();
    load(11'd1400, 11'd1300);
    wait_tick();
    vectors++;
    if (pan_angle !== e1) begin
      miscompares++;
      $display("FAIL hold_pre1: pan=%0d, required %0d", pan_angle, e1);
    end
    wait_tick();
    vectors++;
    if (pan_angle !== e2 || step_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_pre2: pan=%0d tick=%0b, required %0d/0", pan_angle, step_tick, e2);
    end
    hold = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      vectors++;
      if (pan_angle !== e2 || moving !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_frozen%0d: pan=%0d moving=%0b, required %0d/1", k, pan_angle, moving, e2);
      end
    end
    hold = 1'b0;
    wait_tick();
    vectors++;
    if (pan_angle !== e3) begin
      miscompares++;
      $display("FAIL hold_resume: pan=%0d, required %0d", pan_angle, e3);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (pan_angle !== 11'd1300 || tilt_angle !== 11'd1300 ||
        settled !== 1'b0 || moving !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: pan=%0d tilt=%0d settled=%0b moving=%0b, required 1300/1300/0/0",
               pan_angle, tilt_angle, settled, moving);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e1, e2, e3;
`ifdef SLEW_ACCEL_EN
    e1 = 11'd1301; e2 = 11'd1303; e3 = 11'd1302;
`else
    e1 = 11'd1304; e2 = 11'd1308; e3 = 11'd1304;
`endif
    load(11'd1340, 11'd1300);
    wait_tick();
    vectors++;
    if (pan_angle !== e1) begin
      miscompares++;
      $display("FAIL b2b_first: pan=%0d, required %0d", pan_angle, e1);
    end
    // New target lands in the same cycle as step_tick: that step uses 1340.
    wait_tick_pre();
    target_pan   = 11'd1200;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
    vectors++;
    if (pan_angle !== e2) begin
      miscompares++;
      $display("FAIL b2b_old_target: pan=%0d, required %0d", pan_angle, e2);
    end
    wait_tick();
    vectors++;
    if (pan_angle !== e3) begin
      miscompares++;
      $display("FAIL b2b_new_target: pan=%0d, required %0d", pan_angle, e3);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    hold         = 1'b0;
    target_valid = 1'b0;
    target_pan   = 11'd0;
    target_tilt  = 11'd0;
    test_reset();
    test_small_slew();
    test_clamp();
    test_exact_landing();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
